// File: rtl/rb_ctrl.sv
// rb_ctrl: one-instruction-at-a-time sequencer between the instruction
// stream, the rb register bank, and the execute stage.
module rb_ctrl #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [15:0]     instr,
    output logic [3*RW-1:0] rs_out,
    output logic            rw_out,
    output logic [DW-1:0]   d_out,
    input  logic [DW-1:0]   a_in,
    input  logic [DW-1:0]   b_in,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [3:0]      op_code,
    output logic [DW-1:0]   op_a,
    output logic [DW-1:0]   op_b,
    input  logic            res_valid,
    output logic            res_ready,
    input  logic [DW-1:0]   res_data,
    output logic [15:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'hF;

    state_t             state_q, state_d;
    logic [3*RW-1:0]    rs_q, rs_d;
    logic [DW-1:0]      d_q, d_d;
    logic [3:0]         opc_q, opc_d;
    logic [DW-1:0]      opa_q, opa_d;
    logic [DW-1:0]      opb_q, opb_d;
    logic [15:0]        ret_q, ret_d;
    logic               rw_q;

    // Handshake outputs depend on state only, never on inputs.
    assign instr_ready = (state_q == S_IDLE);
    assign op_valid    = (state_q == S_ISSUE);
    assign res_ready   = (state_q == S_WAIT);

    assign rs_out  = rs_q;
    assign rw_out  = rw_q;
    assign d_out   = d_q;
    assign op_code = opc_q;
    assign op_a    = opa_q;
    assign op_b    = opb_q;
    assign retired = ret_q;

    // Next-state and datapath register updates.
    always_comb begin
        state_d = state_q;
        rs_d    = rs_q;
        d_d     = d_q;
        opc_d   = opc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        ret_d   = ret_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    rs_d = instr[3*RW-1:0];
                    if (instr[15:12] == OP_NOP) begin
                        ret_d = ret_q + 16'd1;
                    end else if (instr[15:12] == OP_LDI) begin
                        d_d     = {{(DW-8){1'b0}}, instr[7:0]};
                        state_d = S_WRITE;
                    end else begin
                        opc_d   = instr[15:12];
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                // Operands sampled before any write, so rd may alias ra/rb.
                opa_d   = a_in;
                opb_d   = b_in;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (res_valid) begin
                    d_d     = res_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ret_d   = ret_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; write strobe is high exactly while in WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rs_q    <= '0;
            d_q     <= '0;
            opc_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            ret_q   <= '0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            d_q     <= d_d;
            opc_q   <= opc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            ret_q   <= ret_d;
            rw_q    <= (state_d == S_WRITE);
        end
    end

endmodule

// File: tb/tb_rb_ctrl.sv
// Bench for rb_ctrl: behavioural rb bank and execute stage around the DUT,
// with an architectural register-file model as the reference.
module tb_rb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [11:0] rs_out;
    logic        rw_out;
    logic [15:0] d_out;
    logic [15:0] a_in, b_in;
    logic        op_valid, op_ready;
    logic [3:0]  op_code;
    logic [15:0] op_a, op_b;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [15:0] retired;

    // rb register bank behaviour: combinational reads, write on edge with rw.
    logic [15:0] rbreg [16] = '{default: 16'h0};
    // Architectural reference: what each register should hold.
    logic [15:0] refreg [16] = '{default: 16'h0};
    logic [15:0] exp_ret;
    logic [15:0] exp_d;
    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    assign a_in = rbreg[rs_out[7:4]];
    assign b_in = rbreg[rs_out[3:0]];
    always @(posedge clk) if (rw_out) rbreg[rs_out[11:8]] <= d_out;

    rb_ctrl #(.DW(16), .RW(4)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rs_out(rs_out), .rw_out(rw_out), .d_out(d_out),
        .a_in(a_in), .b_in(b_in),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .retired(retired)
    );

    // Execute-stage function used to produce results.
    function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'h1:    alu = a + b;
            4'h2:    alu = a - b;
            4'h3:    alu = a & b;
            4'h4:    alu = a | b;
            default: alu = (a ^ b) ^ {12'h000, op};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rdy"},  32'(instr_ready), 32'd1);
        chk({tag, "_rs"},   32'(rs_out),      32'd0);
        chk({tag, "_rw"},   32'(rw_out),      32'd0);
        chk({tag, "_d"},    32'(d_out),       32'd0);
        chk({tag, "_opv"},  32'(op_valid),    32'd0);
        chk({tag, "_opc"},  32'(op_code),     32'd0);
        chk({tag, "_opa"},  32'(op_a),        32'd0);
        chk({tag, "_opb"},  32'(op_b),        32'd0);
        chk({tag, "_resr"}, 32'(res_ready),   32'd0);
        chk({tag, "_ret"},  32'(retired),     32'd0);
    endtask

    task automatic do_reset;
        rst = 1'b1; instr_valid = 1'b0; op_ready = 1'b0; res_valid = 1'b0;
        tick; tick;
        rst = 1'b0;
        exp_ret = 16'h0; exp_d = 16'h0;
        chk_reset_outs("reset");
    endtask

    task automatic do_nop(input logic [11:0] f);
        instr_valid = 1'b1; instr = {4'h0, f};
        chk("nop_rdy", 32'(instr_ready), 32'd1);
        tick;
        instr_valid = 1'b0;
        exp_ret = exp_ret + 16'd1;
        chk("nop_ret",  32'(retired),     32'(exp_ret));
        chk("nop_rs",   32'(rs_out),      32'(f));
        chk("nop_d",    32'(d_out),       32'(exp_d));
        chk("nop_rdy2", 32'(instr_ready), 32'd1);
    endtask

    task automatic do_ldi(input logic [3:0] rd, input logic [7:0] imm);
        instr_valid = 1'b1; instr = {4'hF, rd, imm};
        chk("ldi_rdy", 32'(instr_ready), 32'd1);
        tick;
        instr_valid = 1'b0;
        chk("ldi_rw",  32'(rw_out),      32'd1);
        chk("ldi_rs",  32'(rs_out),      32'({rd, imm}));
        chk("ldi_d",   32'(d_out),       32'({8'h00, imm}));
        chk("ldi_busy",32'(instr_ready), 32'd0);
        tick;
        refreg[rd] = {8'h00, imm};
        exp_ret = exp_ret + 16'd1;
        exp_d = {8'h00, imm};
        chk("ldi_rw0", 32'(rw_out),      32'd0);
        chk("ldi_idle",32'(instr_ready), 32'd1);
        chk("ldi_ret", 32'(retired),     32'(exp_ret));
        chk("ldi_reg", 32'(rbreg[rd]),   32'(refreg[rd]));
    endtask

    task automatic do_alu(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                          input logic [3:0] rb, input int stall, input int resdly, input bit stray);
        logic [15:0] ea, eb, res;
        ea = refreg[ra]; eb = refreg[rb]; res = alu(op, ea, eb);
        instr_valid = 1'b1; instr = {op, rd, ra, rb};
        chk("alu_rdy", 32'(instr_ready), 32'd1);
        tick;
        instr_valid = 1'b0;
        // READ
        chk("rd_rs",   32'(rs_out),      32'({rd, ra, rb}));
        chk("rd_busy", 32'(instr_ready), 32'd0);
        chk("rd_opv",  32'(op_valid),    32'd0);
        tick;
        // ISSUE
        chk("is_opv", 32'(op_valid), 32'd1);
        chk("is_opc", 32'(op_code),  32'(op));
        chk("is_opa", 32'(op_a),     32'(ea));
        chk("is_opb", 32'(op_b),     32'(eb));
        for (int i = 0; i < stall; i++) begin
            op_ready = 1'b0;
            if (stray) begin
                res_valid = 1'b1; res_data = 16'hDEAD;
                instr_valid = 1'b1; instr = {4'hF, rd, 8'h5A};
            end
            tick;
            chk("st_opv",  32'(op_valid),    32'd1);
            chk("st_opa",  32'(op_a),        32'(ea));
            chk("st_opb",  32'(op_b),        32'(eb));
            chk("st_opc",  32'(op_code),     32'(op));
            chk("st_busy", 32'(instr_ready), 32'd0);
            chk("st_rw",   32'(rw_out),      32'd0);
            chk("st_resr", 32'(res_ready),   32'd0);
            chk("st_rs",   32'(rs_out),      32'({rd, ra, rb}));
        end
        res_valid = 1'b0; instr_valid = 1'b0;
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
        // WAIT
        chk("wt_resr", 32'(res_ready), 32'd1);
        chk("wt_opv",  32'(op_valid),  32'd0);
        for (int i = 0; i < resdly; i++) begin
            tick;
            chk("wt_resr2", 32'(res_ready), 32'd1);
            chk("wt_rw",    32'(rw_out),    32'd0);
        end
        res_valid = 1'b1; res_data = res;
        tick;
        res_valid = 1'b0; res_data = 16'hBEEF;
        // WRITE
        chk("wr_rw",   32'(rw_out),    32'd1);
        chk("wr_d",    32'(d_out),     32'(res));
        chk("wr_rs",   32'(rs_out),    32'({rd, ra, rb}));
        chk("wr_resr", 32'(res_ready), 32'd0);
        tick;
        refreg[rd] = res;
        exp_ret = exp_ret + 16'd1;
        exp_d = res;
        chk("al_rw0",  32'(rw_out),      32'd0);
        chk("al_idle", 32'(instr_ready), 32'd1);
        chk("al_ret",  32'(retired),     32'(exp_ret));
        chk("al_reg",  32'(rbreg[rd]),   32'(res));
    endtask

    initial begin
        logic [3:0] op, rd, ra, rb;
        logic [15:0] keep;
        rst = 1'b1; instr_valid = 1'b0; instr = 16'h0;
        op_ready = 1'b0; res_valid = 1'b0; res_data = 16'h0;
        exp_ret = 16'h0; exp_d = 16'h0;
        @(negedge clk);
        do_reset;

        do_ldi(4'd3, 8'hA5);

        do_reset;
        do_ldi(4'd1, 8'h05);
        do_ldi(4'd2, 8'h07);
        do_alu(4'h1, 4'd4, 4'd1, 4'd2, 0, 0, 1'b0);
        chk("plan_reg4", 32'(rbreg[4]), 32'h000C);
        chk("plan_ret3", 32'(retired),  32'd3);

        // Execute stall with stray result and stray instruction during ISSUE.
        do_alu(4'h2, 4'd5, 4'd1, 4'd2, 4, 2, 1'b1);

        // Full aliasing: reg1 = reg1 + reg1.
        do_alu(4'h1, 4'd1, 4'd1, 4'd1, 0, 1, 1'b0);
        chk("alias_reg1", 32'(rbreg[1]), 32'h000A);

        // Reset while in WAIT with a result offered on the same edge.
        keep = rbreg[6];
        instr_valid = 1'b1; instr = {4'h1, 4'd6, 4'd1, 4'd2};
        tick;
        instr_valid = 1'b0;
        tick;
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
        chk("rw_wait", 32'(res_ready), 32'd1);
        rst = 1'b1; res_valid = 1'b1; res_data = 16'h1234;
        tick;
        rst = 1'b0; res_valid = 1'b0;
        exp_ret = 16'h0; exp_d = 16'h0;
        chk_reset_outs("rstwait");
        tick;
        chk("rstwait_rw",  32'(rw_out),   32'd0);
        chk("rstwait_reg", 32'(rbreg[6]), 32'(keep));
        do_ldi(4'd7, 8'h3C);

        // Randomized instruction stream.
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            rd = 4'($urandom_range(0, 15));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            if (op == 4'h0)      do_nop({rd, ra, rb});
            else if (op == 4'hF) do_ldi(rd, {ra, rb});
            else do_alu(op, rd, ra, rb, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        for (int r = 0; r < 16; r++) chk($sformatf("bank_r%0d", r), 32'(rbreg[r]), 32'(refreg[r]));

        // Back-to-back NOPs across the counter wrap.
        do_reset;
        instr_valid = 1'b1; instr = 16'h0;
        for (int i = 0; i < 65535; i++) begin
            tick;
            if (i == 2) begin
                chk("nop_b2b_ret", 32'(retired),     32'd3);
                chk("nop_b2b_rdy", 32'(instr_ready), 32'd1);
            end
        end
        chk("wrap_ffff", 32'(retired),     32'hFFFF);
        chk("wrap_rdy",  32'(instr_ready), 32'd1);
        tick;
        instr_valid = 1'b0;
        chk("wrap_zero", 32'(retired), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
